// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
// Build option: BUS_ARB_TIMEOUT_EN enables the forced-rotation hold timer.
package bus_arb_pkg;

    // System bus widths
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    // Hold counter width; MAX_HOLD is limited to 2..255 so it fits
    localparam int HOLD_CNT_W = 8;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Index of a bus master
    typedef logic master_idx_t;

    localparam master_idx_t MASTER0 = 1'b0;
    localparam master_idx_t MASTER1 = 1'b1;

    // Ownership state belonging to a given master
    function automatic arb_state_t own_state(input master_idx_t m);
        return (m == MASTER1) ? OWN1 : OWN0;
    endfunction

    // Next ownership state from the registered state and the sampled requests.
    // A tie from IDLE goes to the master that did not own the bus last.
    // An owner that drops its request hands over directly when the other
    // master is waiting; a preempt moves ownership even if the owner holds on.
    function automatic arb_state_t arb_next_state(
        input arb_state_t  st,
        input logic        req0,
        input logic        req1,
        input master_idx_t last,
        input logic        preempt
    );
        arb_state_t nxt;
        nxt = IDLE;
        case (st)
            IDLE: begin
                if (req0 && req1)
                    nxt = own_state(master_idx_t'(~last));
                else if (req0)
                    nxt = OWN0;
                else if (req1)
                    nxt = OWN1;
                else
                    nxt = IDLE;
            end
            OWN0: begin
                if (req0 && !preempt)
                    nxt = OWN0;
                else if (req1)
                    nxt = OWN1;
                else
                    nxt = IDLE;
            end
            OWN1: begin
                if (req1 && !preempt)
                    nxt = OWN1;
                else if (req0)
                    nxt = OWN0;
                else
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bus_arb_hold_timer.sv
// Hold timer for the bus arbiter: counts cycles the current owner keeps the
// bus while the other master waits, and flags a forced rotation once the
// owner has had MAX_HOLD such cycles. Only instantiated with BUS_ARB_TIMEOUT_EN.
module bus_arb_hold_timer
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_owning,
    input  logic i_owner_req,
    input  logic i_other_req,
    output logic o_preempt
);

    localparam logic [HOLD_CNT_W-1:0] LP_LIMIT = HOLD_CNT_W'(MAX_HOLD - 1);

    logic [HOLD_CNT_W-1:0] r_count;

    // Rotation is due when the limit is reached and the other master still waits
    assign o_preempt = i_owning && i_other_req && (r_count == LP_LIMIT);

    // Count while the owner keeps the bus under contention; any change of
    // ownership (or idle) restarts from zero so every new owner gets a full budget
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_owning && i_owner_req && !o_preempt) begin
            if (i_other_req)
                r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master system bus arbiter (CPU core plus DMA/debug master).
// Registered grants, round-robin tie break, bus mux driven from the
// registered ownership so requests never reach the bus combinationally.
// Build option: define BUS_ARB_TIMEOUT_EN to force rotation after MAX_HOLD
// contended cycles; without it the owner keeps the bus until it lets go.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0Req,
    output logic                  m0Grant,
    input  logic [BUS_ADDR_W-1:0] m0Address,
    input  logic [BUS_DATA_W-1:0] m0DataOut,
    input  logic                  m0WriteEnable,
    output logic [BUS_DATA_W-1:0] m0DataIn,

    input  logic                  m1Req,
    output logic                  m1Grant,
    input  logic [BUS_ADDR_W-1:0] m1Address,
    input  logic [BUS_DATA_W-1:0] m1DataOut,
    input  logic                  m1WriteEnable,
    output logic [BUS_DATA_W-1:0] m1DataIn,

    output logic [BUS_ADDR_W-1:0] address,
    output logic [BUS_DATA_W-1:0] dataOut,
    output logic                  busWriteEnable,
    input  logic [BUS_DATA_W-1:0] dataIn
);

    // Reject hold limits the 8-bit counter cannot represent
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbiter: MAX_HOLD must be in 2..255");
    end

    arb_state_t  r_state;
    master_idx_t r_last_owner;
    logic        r_m0_grant;
    logic        r_m1_grant;

    arb_state_t  w_next_state;
    logic        w_preempt;

`ifdef BUS_ARB_TIMEOUT_EN
    logic w_owning;
    logic w_owner_req;
    logic w_other_req;

    assign w_owning    = (r_state != IDLE);
    assign w_owner_req = r_m0_grant ? m0Req : m1Req;
    assign w_other_req = r_m0_grant ? m1Req : m0Req;

    bus_arb_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_owning    (w_owning),
        .i_owner_req (w_owner_req),
        .i_other_req (w_other_req),
        .o_preempt   (w_preempt)
    );
`else
    assign w_preempt = 1'b0;
`endif

    assign w_next_state = arb_next_state(r_state, m0Req, m1Req, r_last_owner, w_preempt);

    // Ownership FSM: state, last owner and grant flops all move on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_owner <= MASTER1;
            r_m0_grant   <= 1'b0;
            r_m1_grant   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_m0_grant <= (w_next_state == OWN0);
            r_m1_grant <= (w_next_state == OWN1);
            if (w_next_state == OWN0)
                r_last_owner <= MASTER0;
            else if (w_next_state == OWN1)
                r_last_owner <= MASTER1;
        end
    end

    assign m0Grant = r_m0_grant;
    assign m1Grant = r_m1_grant;

    // Bus and read-data routing from the registered owner; a master without
    // the grant sees zero read data and cannot reach the write strobe
    always_comb begin
        address        = '0;
        dataOut        = '0;
        busWriteEnable = 1'b0;
        m0DataIn       = '0;
        m1DataIn       = '0;
        if (r_m0_grant) begin
            address        = m0Address;
            dataOut        = m0DataOut;
            busWriteEnable = m0WriteEnable;
            m0DataIn       = dataIn;
        end else if (r_m1_grant) begin
            address        = m1Address;
            dataOut        = m1DataOut;
            busWriteEnable = m1WriteEnable;
            m1DataIn       = dataIn;
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter sharing the single system bus (address, dataOut, dataIn, busWriteEnable) between the CPU core and a second bus master such as a DMA or debug port. Each master raises a request, waits for a registered grant, and owns the bus until it drops its request. Only the owner's address, data and write strobe reach the bus. Ties are resolved round-robin, and an optional hold timer forces rotation.

## Interface
- MAX_HOLD, 16: cycles an owner may keep the bus while the other master is waiting (used only with BUS_ARB_TIMEOUT_EN); legal range 2..255.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0Req  in  1  master 0 (CPU) bus request
- m0Grant  out  1  master 0 owns the bus
- m0Address  in  32  master 0 address
- m0DataOut  in  32  master 0 write data
- m0WriteEnable  in  1  master 0 write strobe (1 = write)
- m0DataIn  out  32  bus read data to master 0
- m1Req, m1Grant, m1Address, m1DataOut, m1WriteEnable, m1DataIn: same as master 0, for master 1
- address  out  32  bus address
- dataOut  out  32  bus write data
- busWriteEnable  out  1  bus write strobe (1 = WRITE, 0 = READ)
- dataIn  in  32  bus read data

## Operation
- States:
  - IDLE: no owner.
  - OWN0: master 0 owns the bus.
  - OWN1: master 1 owns the bus.
- State is registered. m0Grant = (state == OWN0) and m1Grant = (state == OWN1), both driven directly from flops.
- lastOwner register (1 bit) records the most recent owner.
- IDLE transitions:
  - Only m0Req high: go to OWN0.
  - Only m1Req high: go to OWN1.
  - Both high: grant the master that is not lastOwner.
  - Neither high: stay in IDLE.
- OWNx transitions:
  - While mxReq stays high: stay, unless a forced rotation applies (see Configuration).
  - mxReq low and the other master requesting: go directly to the other master's OWN state. No idle cycle.
  - mxReq low and the other master not requesting: go to IDLE.
- Entering OWNx sets lastOwner = x.
- Bus mux, combinational from the registered state:
  - OWNx: address, dataOut and busWriteEnable follow master x.
  - IDLE: address = 0, dataOut = 0, busWriteEnable = 0.
- Read data: dataIn is routed to the granted master's mxDataIn. The non-granted master's mxDataIn is 0.
- Write protection: a non-granted master's write strobe never reaches busWriteEnable.
- A request dropped while the grant is pending (same cycle) is not an error. The arbiter simply re-evaluates on the next edge.

## Timing
- Reset (asynchronous, reset low) sets:
  - state = IDLE, lastOwner = 1 (master 0 wins the first tie), hold counter = 0.
  - All grants 0; address, dataOut, busWriteEnable 0; m0DataIn and m1DataIn 0.
- Grant latency: a request sampled high at edge N, with the bus free, gives grant high after edge N. The first bus cycle for that master is cycle N+1.
- Release: a request sampled low at edge N gives grant low after edge N. Handover to a waiting master completes at the same edge.
- Ownership changes only at clock edges. No combinational path runs from mxReq to any grant or bus output.
- A master must keep its address, data and strobe stable only while its grant is high. Values driven while not granted are ignored.
- Reset asserted mid-transfer drops the grant and bus strobe immediately (asynchronously). After reset releases, the first owner is selected by the IDLE tie rule (lastOwner = 1).

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to any OWN state and increments each cycle the owner keeps the bus while the other master requests.
  - When the counter reaches MAX_HOLD−1 with the other master still requesting, the next edge forces a transition to the other OWN state, even though the owner still requests.
  - The preempted master sees its grant fall and must re-request.
- BUS_ARB_TIMEOUT_EN undefined: no counter logic exists. The owner keeps the bus until it drops its request, and MAX_HOLD is ignored.

## Structure
- Shared package bus_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1);
  - the master-index type;
  - bus width constants (32-bit address/data).
- One sub-module is natural: bus_arb_hold_timer. It contains the counter and the preempt compare, and is instantiated only under BUS_ARB_TIMEOUT_EN.
- The mux and FSM stay in bus_arbiter.

## Test plan
- Reset pulse mid-grant (m0 owning, m0WriteEnable = 1) → within the reset-low interval all grants = 0, busWriteEnable = 0, address = 0. After release, m0Req & m1Req both high → m0Grant first.
- m0Req only, m0Address = 0x100, m0WriteEnable = 1 → m0Grant = 1 one cycle later, bus address = 0x100, busWriteEnable = 1. m1Grant = 0 and m1DataIn = 0 throughout.
- Both requests held, owner drops each time after 3 cycles → ownership alternates m0, m1, m0 with no IDLE cycle between owners.
- m1 owns, m0 drives m0WriteEnable = 1 with m0Address = 0xDEAD → bus shows m1 values only and busWriteEnable follows m1WriteEnable. dataIn = 0x12345678 appears on m1DataIn only.
- BUS_ARB_TIMEOUT_EN, MAX_HOLD = 4, m0 holds its request while m1 requests → m0Grant falls and m1Grant rises after exactly 4 owned cycles. Repeat without the macro → m0 keeps the bus indefinitely.
